universal_shift_engine: RTL
===========================

// Module: universal_shift_engine
// PURPOSE
//  Parametrised multi-mode shift register with a command handshake. Successor
//  to the single-step serial/parallel shift register in the datapath.
//  Performs load, clear, logical/arithmetic shift and rotate by a programmable
//  amount, shifting STEP bits per cycle, and signals completion.
//  Serves the ALU/serial-I/O datapath wherever multi-bit shifts are needed.
// PARAMETERS
//  W     8  register width in bits, W >= 2
//  STEP  1  maximum bits shifted per cycle, 1 <= STEP <= W
//  AMW   derived localparam = $clog2(W+1), width of the shift amount
// PORTS
//  clk        in   1    clock; all state changes on the rising edge
//  rst        in   1    synchronous reset, active-high
//  cmd_valid  in   1    command present
//  cmd_ready  out  1    engine can accept a command (state==IDLE)
//  cmd_op     in   3    0 LOAD, 1 CLEAR, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR, 7 NOP
//  cmd_amt    in   AMW  shift/rotate amount; ignored by LOAD/CLEAR/NOP
//  din        in   W    parallel load data for LOAD
//  si_left    in   1    fill bit entering at the MSB for SHR
//  si_right   in   1    fill bit entering at the LSB for SHL
//  q          out  W    register contents
//  so_left    out  1    last bit shifted out of the MSB (SHL/ROL)
//  so_right   out  1    last bit shifted out of the LSB (SHR/ROR/ASR)
//  busy       out  1    multi-cycle shift in progress (state==SHIFT)
//  done       out  1    one-cycle pulse: the command has completed
// BEHAVIOUR
//  Reset: q=0, so_left=0, so_right=0, busy=0, done=0, state=IDLE, remaining
//   count=0. Reset overrides everything, including a command in the same
//   cycle, and aborts an in-flight shift. No done pulse for an aborted command.
//  FSM: IDLE, SHIFT. cmd_ready=1 only in IDLE, and is combinational from the
//   state. A command is accepted on an edge where cmd_valid && cmd_ready.
//  IDLE accept, LOAD: q<=din. CLEAR: q<=0. NOP: q unchanged. Any shift op with
//   effective amount 0: q unchanged. In each of these cases the state stays
//   IDLE and done=1 in the next cycle.
//  IDLE accept, shift op with amt>0: the effective amount is min(cmd_amt,W).
//   The op, the amount and the fill bits are latched at accept. Later changes
//   on si_left/si_right have no effect. The state moves to SHIFT and no bits
//   move on the accept edge.
//  SHIFT: each edge shifts k=min(STEP,remaining) bits and sets
//   remaining-=k. When remaining reaches 0 the state returns to IDLE and done=1
//   for the following cycle. Shift latency from accept is ceil(amt/STEP)
//   cycles of busy=1. done occurs in the first cycle in which q holds the final
//   value.
//  Op semantics per k-bit step:
//   - SHL: q<={q[W-1-k:0],{k{si_right}}}
//   - SHR: q<={{k{si_left}},q[W-1:k]}
//   - ASR: fill with the current q[W-1]
//   - ROL/ROR: rotate by k
//   - When k==W: SHL/SHR/ASR result is all fill bits, and a rotate leaves q
//     unchanged.
//  so_left/so_right: updated only on shift edges of the matching direction.
//   The value is the last bit to leave on that edge: SHL/ROL q[W-k], and
//   SHR/ROR/ASR q[k-1]. Otherwise held.
//  done and the accept cycle may coincide: ready=1 while done=1, so
//   back-to-back commands are accepted with no bubble.
//  cmd_op/cmd_amt/din are sampled only at accept; they are don't-care
//   otherwise.
// TESTING
//  1 W=8,STEP=1: LOAD 0x81, then SHL amt=3 si_right=1 -> busy 3 cycles,
//    q=0x0F, so_left=0, single done pulse.
//  2 W=8,STEP=2: LOAD 0x90, then ASR amt=3 -> busy 2 cycles, q=0xF2,
//    so_right=0.
//  3 W=8,STEP=1: LOAD 0x01, then ROR amt=9 (clamped to 8) -> busy 8 cycles,
//    q=0x01, so_right=0.
//  4 LOAD 0xA5, SHL amt=5, rst=1 on the 2nd busy cycle -> next cycle q=0,
//    busy=0, ready=1, no done.
//  5 LOAD 0x3C with cmd_valid held, ROL amt=1 accepted in the done cycle ->
//    q=0x78 one cycle later, no idle bubble.
//  6 SHR amt=0 and NOP -> q unchanged, busy never 1, done exactly 1 cycle
//    after accept.

Source files
------------

// File: rtl/universal_shift_engine.sv
// Multi-mode shift register with a command handshake: load, clear, shifts and
// rotates by a programmable amount, moving up to STEP bits per clock.
module universal_shift_engine #(
   parameter  int W    = 8,
   parameter  int STEP = 1,
   localparam int AMW  = $clog2(W + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic [2:0]     cmd_op,
   input  logic [AMW-1:0] cmd_amt,
   input  logic [W-1:0]   din,
   input  logic           si_left,
   input  logic           si_right,
   output logic [W-1:0]   q,
   output logic           so_left,
   output logic           so_right,
   output logic           busy,
   output logic           done
);

   typedef enum logic [2:0] {
      OP_LOAD  = 3'd0,
      OP_CLEAR = 3'd1,
      OP_SHL   = 3'd2,
      OP_SHR   = 3'd3,
      OP_ROL   = 3'd4,
      OP_ROR   = 3'd5,
      OP_ASR   = 3'd6,
      OP_NOP   = 3'd7
   } op_t;

   typedef enum logic {IDLE, SHIFT} state_t;

   localparam logic [AMW-1:0] STEP_A = AMW'(STEP);
   localparam logic [AMW-1:0] W_A    = AMW'(W);

   state_t         state, state_nxt;
   op_t            op_in, op_r;
   logic [AMW-1:0] rem, amt_eff, k;
   logic           fill_l, fill_r;
   logic           accept, is_shift, last_step;
   logic [W-1:0]   q_sh;
   logic           sol_sh, sor_sh;

   assign op_in     = op_t'(cmd_op);
   assign cmd_ready = (state == IDLE);
   assign busy      = (state == SHIFT);
   assign accept    = cmd_valid && cmd_ready;
   assign amt_eff   = (cmd_amt > W_A) ? W_A : cmd_amt;
   assign is_shift  = (op_in inside {OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR});
   assign k         = (rem < STEP_A) ? rem : STEP_A;
   assign last_step = (rem <= STEP_A);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every variable written in an always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && is_shift && (amt_eff != '0)) state_nxt = SHIFT;
         SHIFT:   if (last_step) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A k-bit step is built from k single-bit steps, which also yields the
   // last bit to leave on each side.
   always_comb begin
      q_sh   = q;
      sol_sh = so_left;
      sor_sh = so_right;
      for (int i = 0; i < STEP; i++) begin
         if (AMW'(i) < k) begin
            case (op_r)
               OP_SHL: begin
                  sol_sh = q_sh[W-1];
                  q_sh   = {q_sh[W-2:0], fill_r};
               end
               OP_ROL: begin
                  sol_sh = q_sh[W-1];
                  q_sh   = {q_sh[W-2:0], q_sh[W-1]};
               end
               OP_SHR: begin
                  sor_sh = q_sh[0];
                  q_sh   = {fill_l, q_sh[W-1:1]};
               end
               OP_ASR: begin
                  sor_sh = q_sh[0];
                  q_sh   = {q_sh[W-1], q_sh[W-1:1]};
               end
               OP_ROR: begin
                  sor_sh = q_sh[0];
                  q_sh   = {q_sh[0], q_sh[W-1:1]};
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q        <= '0;
         so_left  <= 1'b0;
         so_right <= 1'b0;
         done     <= 1'b0;
         rem      <= '0;
         op_r     <= OP_NOP;
         fill_l   <= 1'b0;
         fill_r   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (accept) begin
               case (op_in)
                  OP_LOAD:  q <= din;
                  OP_CLEAR: q <= '0;
                  default:  ;
               endcase
               op_r   <= op_in;
               rem    <= is_shift ? amt_eff : '0;
               fill_l <= si_left;
               fill_r <= si_right;
               // Zero-length commands finish on the accept edge itself.
               if (!(is_shift && (amt_eff != '0))) done <= 1'b1;
            end
         end else begin
            q        <= q_sh;
            so_left  <= sol_sh;
            so_right <= sor_sh;
            rem      <= rem - k;
            if (last_step) done <= 1'b1;
         end
      end
   end

endmodule
